// File: rtl/cic_comb.sv
// CIC decimator comb section: N_STAGES cascaded y[n] = x[n] - x[n-M] stages,
// advanced by a valid strobe in the system clock domain, plus a sticky settled flag.
module cic_comb #(
   parameter int WIDTH      = 16,
   parameter int N_STAGES   = 3,
   parameter int DIFF_DELAY = 1,
   parameter int OUT_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     in_data,
   input  logic                 in_valid,
   output logic [OUT_WIDTH-1:0] out_data,
   output logic                 out_valid,
   output logic                 settled
);

   localparam int unsigned SETTLE_N = N_STAGES * DIFF_DELAY;
   localparam int unsigned CNT_W    = $clog2(SETTLE_N + 1);

   if (OUT_WIDTH > WIDTH || N_STAGES < 1 || (DIFF_DELAY != 1 && DIFF_DELAY != 2)) begin : g_param_check
      $fatal(1, "cic_comb: invalid parameter combination");
   end

   logic [WIDTH-1:0] sdata [N_STAGES+1];
   logic             svld  [N_STAGES+1];
   logic             stag  [N_STAGES+1];
   logic [CNT_W-1:0] cnt_q;
   logic             settled_q;

   assign sdata[0] = in_data;
   assign svld[0]  = in_valid;
   // tag marks samples whose result no longer sees reset-state history
   assign stag[0]  = (cnt_q == CNT_W'(SETTLE_N));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (in_valid && cnt_q != CNT_W'(SETTLE_N)) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   for (genvar k = 0; k < N_STAGES; k++) begin : g_stage
      logic [WIDTH-1:0] dly_q [DIFF_DELAY];
      logic [WIDTH-1:0] res_q;
      logic             vld_q;
      logic             tag_q;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            res_q <= '0;
            vld_q <= 1'b0;
            tag_q <= 1'b0;
            for (int unsigned i = 0; i < DIFF_DELAY; i++) begin
               dly_q[i] <= '0;
            end
         end else begin
            vld_q <= svld[k];
            tag_q <= svld[k] & stag[k];
            if (svld[k]) begin
               res_q    <= sdata[k] - dly_q[DIFF_DELAY-1];
               dly_q[0] <= sdata[k];
               for (int unsigned i = 1; i < DIFF_DELAY; i++) begin
                  dly_q[i] <= dly_q[i-1];
               end
            end
         end
      end

      assign sdata[k+1] = res_q;
      assign svld[k+1]  = vld_q;
      assign stag[k+1]  = tag_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         settled_q <= 1'b0;
      end else begin
         settled_q <= settled;
      end
   end

   // combinational term lets settled rise together with the qualifying out_valid
   assign settled   = settled_q | (svld[N_STAGES] & stag[N_STAGES]);
   assign out_valid = svld[N_STAGES];
   assign out_data  = sdata[N_STAGES][WIDTH-1 -: OUT_WIDTH];

endmodule
